flappy_game_ctrl: RTL and testbench
===================================

// Module: flappy_game_ctrl
// PURPOSE
//  Game-state controller directly upstream of the bitgen pixel stage.
//  Once per video frame it advances bird physics, scrolls the pipe, draws a new pipe gap
//  from an LFSR, detects collisions and keeps the score.
//  It drives start_game, end_game, bird_1_height, pipe_height and pipe_x into bitgen.
//  Vertical positions use 2-pixel units (row = 2*value); horizontal positions use pixels.
// PARAMETERS
//  BIRD_X      305  bird left edge, px (the centred 30-px square)
//  BIRD_W      30   bird width, px
//  BIRD_H      15   bird height, 2-px units
//  BIRD_START  112  bird top on game start, 2-px units
//  Y_MAX       240  screen height, 2-px units
//  GRAVITY     1    added to velocity each frame
//  FLAP_VEL    6    a flap sets velocity to -FLAP_VEL
//  MAX_FALL    8    velocity upper clamp
//  PIPE_W      50   pipe width, px
//  PIPE_START  640  pipe_x on spawn/wrap, px
//  PIPE_SPEED  2    px of scroll per frame
//  GAP         60   gap height, 2-px units
//  GAP_MIN     20   minimum gap top, 2-px units
//  DEAD_HOLD   60   frames in which flap is ignored in DEAD
// PORTS
//  clk            in   1   system/pixel clock
//  rst            in   1   asynchronous, active-high reset
//  frame_tick     in   1   1-cycle pulse per frame (start of vertical blank)
//  flap_btn       in   1   synchronised, debounced flap button, level
//  start_game     out  1   1 = title screen
//  end_game       out  1   1 = game-over screen
//  bird_1_height  out  8   bird top, 2-px units
//  pipe_height    out  8   gap top, 2-px units
//  pipe_x         out  10  pipe left edge, px
//  score          out  8   pipes passed, saturates at 255
// BEHAVIOUR
//  Reset: state=TITLE, start_game=1, end_game=0, bird_1_height=BIRD_START, pipe_height=GAP_MIN,
//    pipe_x=PIPE_START, score=0, vel=0, lfsr=8'hA5, flap_pend=0, hold_cnt=0.
//  Flap capture: a rising edge of flap_btn (vs. last-cycle register) sets flap_pend.
//    flap_pend clears on the next frame_tick. An edge in the same cycle as frame_tick counts for that tick.
//  LFSR: 8-bit Fibonacci, x^8+x^6+x^5+x^4+1, steps every clk in all states; never all-zero.
//  All state/outputs change only on frame_tick (except reset). Outputs are registered and
//    valid the cycle after the tick.
//  FSM:
//   TITLE: on tick with flap_pend -> PLAY. Load bird=BIRD_START, vel=0, pipe_x=PIPE_START, score=0,
//     and pipe_height=GAP_MIN+lfsr[5:0].
//   PLAY: on tick:
//     vel' = flap_pend ? -FLAP_VEL : min(vel+GRAVITY, MAX_FALL)   (signed 6-bit)
//     ny = bird+vel' (signed 10-bit); bird' = clamp(ny, 0, Y_MAX-BIRD_H)
//     if pipe_x < PIPE_SPEED: pipe_x'=PIPE_START, pipe_height'=GAP_MIN+lfsr[5:0], score'=sat(score+1)
//     else pipe_x' = pipe_x-PIPE_SPEED
//     floor = (ny >= Y_MAX-BIRD_H)
//     hit = (pipe_x' < BIRD_X+BIRD_W) && (pipe_x'+PIPE_W > BIRD_X) &&
//           (bird' < pipe_height' || bird'+BIRD_H > pipe_height'+GAP)   (11-bit compares)
//     floor|hit -> DEAD, hold_cnt=0; new positions still commit. Both together = single DEAD entry.
//     Ceiling (ny<0) clamps to 0 and is not fatal.
//   DEAD: positions frozen, score held; hold_cnt increments per tick, saturating at DEAD_HOLD.
//     On tick with hold_cnt==DEAD_HOLD and flap_pend -> TITLE (score kept until next PLAY).
//  start_game = (state==TITLE); end_game = (state==DEAD); never both 1.
//  Async reset mid-frame returns every register to reset values immediately.
// TESTING
//  1 Assert rst during PLAY at score 3 -> same cycle: start_game=1, pipe_x=640, score=0, bird=112.
//  2 TITLE, pulse flap_btn, then tick -> start_game=0, bird=112, pipe_x=640, pipe_height in [20,83].
//  3 PLAY with no flaps -> vel 1..8; bird 113,115,118,122,...; end_game=1 when the bird reaches 225.
//  4 Flap every 4th tick, gap forced by LFSR seed -> pipe_x 638,636,...,0, then wraps to 640,
//    score=1, new pipe_height.
//  5 Flap every tick (bird clamps to 0) -> end_game=1 on the first tick with pipe_x' < 335.
//  6 DEAD: flap at tick 10 -> ignored; flap after 60 ticks -> start_game=1, end_game=0.

Source files
------------

// File: rtl/flappy_game_ctrl_if.sv
// Frame-rate controls into, and game-state outputs out of, the flappy game controller.
// master = the controller; slave = whoever drives ticks/flaps and consumes the state (bitgen side).
interface flappy_game_ctrl_if;
  logic       frame_tick;
  logic       flap_btn;
  logic       start_game;
  logic       end_game;
  logic [7:0] bird_1_height;
  logic [7:0] pipe_height;
  logic [9:0] pipe_x;
  logic [7:0] score;

  modport master (
    input  frame_tick, flap_btn,
    output start_game, end_game, bird_1_height, pipe_height, pipe_x, score
  );

  modport slave (
    output frame_tick, flap_btn,
    input  start_game, end_game, bird_1_height, pipe_height, pipe_x, score
  );
endinterface

// File: rtl/flappy_game_ctrl.sv
// Per-frame game state for bitgen: bird physics, pipe scroll/respawn, collision, score.
// All state advances on frame_tick; outputs are registered, valid the cycle after the tick.
module flappy_game_ctrl #(
  parameter int BIRD_X     = 305,
  parameter int BIRD_W     = 30,
  parameter int BIRD_H     = 15,
  parameter int BIRD_START = 112,
  parameter int Y_MAX      = 240,
  parameter int GRAVITY    = 1,
  parameter int FLAP_VEL   = 6,
  parameter int MAX_FALL   = 8,
  parameter int PIPE_W     = 50,
  parameter int PIPE_START = 640,
  parameter int PIPE_SPEED = 2,
  parameter int GAP        = 60,
  parameter int GAP_MIN    = 20,
  parameter int DEAD_HOLD  = 60
) (
  input  logic               clk,
  input  logic               rst,
  flappy_game_ctrl_if.master bus
);

  typedef enum logic [1:0] {TITLE, PLAY, DEAD} state_t;

  localparam logic signed [5:0] GRAV_V     = 6'(GRAVITY);
  localparam logic signed [5:0] MAX_FALL_V = 6'(MAX_FALL);
  localparam logic signed [5:0] FLAP_V     = 6'(-FLAP_VEL);
  localparam logic signed [9:0] Y_LIM_S    = 10'(Y_MAX - BIRD_H);
  localparam logic [7:0]        Y_LIM_V    = 8'(Y_MAX - BIRD_H);
  localparam logic [5:0]        HOLD_V     = 6'(DEAD_HOLD);

  state_t            state, state_nxt;
  logic [7:0]        bird;
  logic signed [5:0] vel;
  logic [9:0]        pipe_x;
  logic [7:0]        pipe_height;
  logic [7:0]        score;
  logic [7:0]        lfsr;
  logic              flap_q;
  logic              flap_pend;
  logic [5:0]        hold_cnt;

  logic              flap_edge;
  logic              flap_now;
  logic              lfsr_fb;
  logic [7:0]        ph_spawn;

  logic signed [5:0] vel_inc;
  logic signed [5:0] vel_nxt;
  logic signed [9:0] ny;
  logic              ny_floor;
  logic [7:0]        bird_play;
  logic              wrap;
  logic [9:0]        px_play;
  logic [7:0]        ph_play;
  logic [7:0]        score_play;
  logic [10:0]       px11, bird11, ph11;
  logic              hit;
  logic              die;
  logic              start_int, end_int;

  // A rising edge coincident with the tick is folded straight into that tick's decision.
  assign flap_edge = bus.flap_btn & ~flap_q;
  assign flap_now  = flap_pend | flap_edge;
  assign lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign ph_spawn  = 8'(GAP_MIN) + {2'b00, lfsr[5:0]};

  always_comb begin
    vel_inc    = vel + GRAV_V;
    vel_nxt    = flap_now ? FLAP_V : ((vel_inc > MAX_FALL_V) ? MAX_FALL_V : vel_inc);
    ny         = $signed({2'b00, bird}) + $signed({{4{vel_nxt[5]}}, vel_nxt});
    ny_floor   = (ny >= Y_LIM_S);
    bird_play  = ny[9] ? 8'd0 : (ny_floor ? Y_LIM_V : ny[7:0]);
    wrap       = (pipe_x < 10'(PIPE_SPEED));
    px_play    = wrap ? 10'(PIPE_START) : (pipe_x - 10'(PIPE_SPEED));
    ph_play    = wrap ? ph_spawn : pipe_height;
    score_play = (wrap && score != 8'hFF) ? (score + 8'd1) : score;
    px11       = {1'b0, px_play};
    bird11     = {3'b000, bird_play};
    ph11       = {3'b000, ph_play};
    hit        = (px11 < 11'(BIRD_X + BIRD_W)) &&
                 ((px11 + 11'(PIPE_W)) > 11'(BIRD_X)) &&
                 ((bird11 < ph11) || ((bird11 + 11'(BIRD_H)) > (ph11 + 11'(GAP))));
    die        = ny_floor | hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= TITLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (bus.frame_tick) begin
      case (state)
        TITLE:   if (flap_now) state_nxt = PLAY;
        PLAY:    if (die) state_nxt = DEAD;
        DEAD:    if (hold_cnt == HOLD_V && flap_now) state_nxt = TITLE;
        default: state_nxt = TITLE;
      endcase
    end
  end

  always_comb begin
    start_int = (state == TITLE);
    end_int   = (state == DEAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bird        <= 8'(BIRD_START);
      vel         <= '0;
      pipe_x      <= 10'(PIPE_START);
      pipe_height <= 8'(GAP_MIN);
      score       <= '0;
      lfsr        <= 8'hA5;
      flap_q      <= 1'b0;
      flap_pend   <= 1'b0;
      hold_cnt    <= '0;
    end else begin
      lfsr   <= {lfsr[6:0], lfsr_fb};
      flap_q <= bus.flap_btn;
      if (bus.frame_tick) begin
        flap_pend <= 1'b0;
      end else if (flap_edge) begin
        flap_pend <= 1'b1;
      end
      if (bus.frame_tick) begin
        case (state)
          TITLE: begin
            if (flap_now) begin
              bird        <= 8'(BIRD_START);
              vel         <= '0;
              pipe_x      <= 10'(PIPE_START);
              pipe_height <= ph_spawn;
              score       <= '0;
            end
          end
          PLAY: begin
            // The fatal frame still commits its positions so the crash is drawn where it happened.
            vel         <= vel_nxt;
            bird        <= bird_play;
            pipe_x      <= px_play;
            pipe_height <= ph_play;
            score       <= score_play;
            if (die) hold_cnt <= '0;
          end
          DEAD: begin
            if (hold_cnt != HOLD_V) hold_cnt <= hold_cnt + 6'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.start_game    = start_int;
  assign bus.end_game      = end_int;
  assign bus.bird_1_height = bird;
  assign bus.pipe_height   = pipe_height;
  assign bus.pipe_x        = pipe_x;
  assign bus.score         = score;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Bench for flappy_game_ctrl: frame-level reference model feeding a scoreboard, plus a
// table of free-fall vectors and hand sequences for dead-hold, clamping, wrap and async reset.
module tb_flappy_game_ctrl;

  typedef struct {
    bit start_g;
    bit end_g;
    int bird;
    int ph;
    int px;
    int score;
  } exp_t;

  typedef struct {
    bit flap;
    int bird;
    bit end_g;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  flappy_game_ctrl_if bus();

  flappy_game_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb_q[$];

  int m_state, m_bird, m_vel, m_px, m_ph, m_score, m_hold;
  bit pend;
  logic [7:0] m_lfsr;

  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 8'hA5;
    else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic model_reset();
    m_state = 0; m_bird = 112; m_vel = 0; m_px = 640; m_ph = 20; m_score = 0; m_hold = 0;
    pend = 1'b0;
  endtask

  task automatic model_tick(input bit flap);
    exp_t e;
    int ny, nb;
    case (m_state)
      0: begin
        if (flap) begin
          m_state = 1; m_bird = 112; m_vel = 0; m_px = 640; m_score = 0;
          m_ph = 20 + int'(m_lfsr[5:0]);
        end
      end
      1: begin
        m_vel = flap ? -6 : ((m_vel + 1 > 8) ? 8 : m_vel + 1);
        ny = m_bird + m_vel;
        nb = (ny < 0) ? 0 : ((ny > 225) ? 225 : ny);
        if (m_px < 2) begin
          m_px = 640;
          m_ph = 20 + int'(m_lfsr[5:0]);
          if (m_score < 255) m_score = m_score + 1;
        end else begin
          m_px = m_px - 2;
        end
        m_bird = nb;
        if (ny >= 225 ||
            (m_px < 335 && m_px + 50 > 305 && (nb < m_ph || nb + 15 > m_ph + 60))) begin
          m_state = 2;
          m_hold  = 0;
        end
      end
      default: begin
        if (m_hold == 60 && flap) m_state = 0;
        else if (m_hold < 60)     m_hold = m_hold + 1;
      end
    endcase
    e.start_g = (m_state == 0);
    e.end_g   = (m_state == 2);
    e.bird    = m_bird;
    e.ph      = m_ph;
    e.px      = m_px;
    e.score   = m_score;
    sb_q.push_back(e);
  endtask

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic sb_check();
    exp_t e;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_bad++;
      $display("FAIL sb_empty: DUT produced a frame with no expectation queued (t=%0t)", $time);
    end else begin
      e = sb_q.pop_front();
      if (bus.start_game !== e.start_g || bus.end_game !== e.end_g ||
          int'(bus.bird_1_height) !== e.bird || int'(bus.pipe_height) !== e.ph ||
          int'(bus.pipe_x) !== e.px || int'(bus.score) !== e.score ||
          (bus.start_game && bus.end_game)) begin
        n_bad++;
        $display("FAIL frame: got st=%0b end=%0b bird=%0d ph=%0d px=%0d sc=%0d, expected st=%0b end=%0b bird=%0d ph=%0d px=%0d sc=%0d (t=%0t)",
                 bus.start_game, bus.end_game, bus.bird_1_height, bus.pipe_height,
                 bus.pipe_x, bus.score, e.start_g, e.end_g, e.bird, e.ph, e.px, e.score, $time);
      end
    end
  endtask

  // One frame: optional flap pulse ahead of the tick (or coincident with it), then the tick.
  task automatic frame(input bit flap, input bit same_cycle);
    if (flap && !same_cycle) begin
      @(negedge clk); bus.flap_btn = 1'b1; pend = 1'b1;
      @(negedge clk); bus.flap_btn = 1'b0;
    end
    @(negedge clk);
    bus.frame_tick = 1'b1;
    if (flap && same_cycle) begin
      bus.flap_btn = 1'b1;
      pend = 1'b1;
    end
    model_tick(pend);
    pend = 1'b0;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    if (flap && same_cycle) bus.flap_btn = 1'b0;
    sb_check();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start"}, int'(bus.start_game), 1);
    check({tag, "_end"},   int'(bus.end_game), 0);
    check({tag, "_bird"},  int'(bus.bird_1_height), 112);
    check({tag, "_ph"},    int'(bus.pipe_height), 20);
    check({tag, "_px"},    int'(bus.pipe_x), 640);
    check({tag, "_score"}, int'(bus.score), 0);
  endtask

  initial begin
    vec_t vec[18];
    int   fall[18] = '{113, 115, 118, 122, 127, 133, 140, 148, 156,
                       164, 172, 180, 188, 196, 204, 212, 220, 225};
    bit   wrap_seen;
    for (int i = 0; i < 18; i++) begin
      vec[i].flap  = 1'b0;
      vec[i].bird  = fall[i];
      vec[i].end_g = (i == 17);
    end

    bus.frame_tick = 1'b0;
    bus.flap_btn   = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;

    // TITLE ignores ticks without a flap, then starts on a flap.
    frame(1'b0, 1'b0);
    frame(1'b1, 1'b0);
    check("start_ph_range", int'(bus.pipe_height >= 8'd20 && bus.pipe_height <= 8'd83), 1);
    check("start_px", int'(bus.pipe_x), 640);

    // Free fall from the start height until the floor kills the bird.
    for (int i = 0; i < 18; i++) begin
      frame(vec[i].flap, 1'b0);
      check($sformatf("fall_bird_%0d", i), int'(bus.bird_1_height), vec[i].bird);
      check($sformatf("fall_end_%0d", i), int'(bus.end_game), int'(vec[i].end_g));
    end

    // Dead hold: flaps at tick 10 and 60 are ignored, the one after is accepted.
    for (int t = 1; t <= 60; t++) begin
      frame(t == 10 || t == 60, 1'b0);
      if (t == 10 || t == 60) check($sformatf("dead_hold_%0d", t), int'(bus.end_game), 1);
    end
    frame(1'b1, 1'b0);
    check("dead_exit_start", int'(bus.start_game), 1);
    check("dead_exit_end", int'(bus.end_game), 0);

    // Flap edge coincident with the tick starts play; then flap every tick to the ceiling.
    frame(1'b1, 1'b1);
    check("same_cycle_start", int'(bus.start_game), 0);
    for (int k = 0; k < 200; k++) begin
      frame(1'b1, 1'b0);
      if (m_state == 2) break;
    end
    check("ceiling_death_px", int'(bus.pipe_x), 334);
    check("ceiling_death_bird", int'(bus.bird_1_height), 0);
    check("ceiling_death_end", int'(bus.end_game), 1);

    repeat (60) frame(1'b0, 1'b0);
    frame(1'b1, 1'b0);

    // A held button counts once: start play, then the next tick must fall, not flap.
    @(negedge clk); bus.flap_btn = 1'b1; pend = 1'b1;
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);
    check("level_no_reflap", int'(bus.bird_1_height), 113);
    @(negedge clk); bus.flap_btn = 1'b0;

    // Hover inside the gap (policy from the model) through three pipe wraps.
    wrap_seen = 1'b0;
    for (int k = 0; k < 1400 && m_score < 3 && m_state == 1; k++) begin
      frame((m_bird > m_ph + 26) && (m_vel > 0), 1'b0);
      if (!wrap_seen && m_score == 1) begin
        wrap_seen = 1'b1;
        check("wrap_px", int'(bus.pipe_x), 640);
        check("wrap_score", int'(bus.score), 1);
      end
    end
    check("hover_score", int'(bus.score), 3);
    check("hover_alive", int'(bus.end_game), 0);

    // Asynchronous reset in the middle of a clock cycle.
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    model_reset();
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    frame(1'b1, 1'b0);
    check("post_rst_start", int'(bus.start_game), 0);

    check("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
